// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard path: protocol bytes, byte-FSM
// state encoding and the ASCII codes the game logic compares against.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BRK    = 8'hF0;
   localparam logic [7:0] PS2_BAT_OK = 8'hAA;
   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_ECHO   = 8'hEE;
   localparam logic [7:0] PS2_RESEND = 8'hFE;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_EXT     = 2'd1;
   localparam logic [1:0] ST_BRK     = 2'd2;
   localparam logic [1:0] ST_EXT_BRK = 2'd3;

   localparam logic [7:0] ASC_ENTER = 8'd13;
   localparam logic [7:0] ASC_SPACE = 8'h20;

   // Keyboard housekeeping replies that carry no key information.
   function automatic logic is_ignored(input logic [7:0] code);
      return (code == PS2_BAT_OK) || (code == PS2_ACK) ||
             (code == PS2_ECHO)   || (code == PS2_RESEND);
   endfunction

endpackage

// File: rtl/ps2_scan_to_ascii.sv
// Combinational scan-code-set-2 to ASCII lookup; 8'h00 marks an unmapped key.
module ps2_scan_to_ascii
   import ps2_pkg::*;
(
   input  logic [8:0] key,
   output logic [7:0] ascii
);

   logic       ext;
   logic [7:0] code;
   logic [7:0] base;

   assign ext  = key[8];
   assign code = key[7:0];

   always_comb begin
      base = 8'h00;
      case (code)
         8'h1C: base = 8'h61;
         8'h32: base = 8'h62;
         8'h21: base = 8'h63;
         8'h23: base = 8'h64;
         8'h24: base = 8'h65;
         8'h2B: base = 8'h66;
         8'h34: base = 8'h67;
         8'h33: base = 8'h68;
         8'h43: base = 8'h69;
         8'h3B: base = 8'h6A;
         8'h42: base = 8'h6B;
         8'h4B: base = 8'h6C;
         8'h3A: base = 8'h6D;
         8'h31: base = 8'h6E;
         8'h44: base = 8'h6F;
         8'h4D: base = 8'h70;
         8'h15: base = 8'h71;
         8'h2D: base = 8'h72;
         8'h1B: base = 8'h73;
         8'h2C: base = 8'h74;
         8'h3C: base = 8'h75;
         8'h2A: base = 8'h76;
         8'h1D: base = 8'h77;
         8'h22: base = 8'h78;
         8'h35: base = 8'h79;
         8'h1A: base = 8'h7A;
         8'h45: base = 8'h30;
         8'h16: base = 8'h31;
         8'h1E: base = 8'h32;
         8'h26: base = 8'h33;
         8'h25: base = 8'h34;
         8'h2E: base = 8'h35;
         8'h36: base = 8'h36;
         8'h3D: base = 8'h37;
         8'h3E: base = 8'h38;
         8'h46: base = 8'h39;
         8'h29: base = ASC_SPACE;
         8'h5A: base = ASC_ENTER;
         default: base = 8'h00;
      endcase
   end

   // Only the keypad Enter exists in the extended set among mapped keys.
   assign ascii = (!ext || code == 8'h5A) ? base : 8'h00;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 receiver and set-2 key decoder: frames bytes off the raw lines, tracks
// E0/F0 prefixes and presents the held key as ASCII with press/release strobes.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int TIMEOUT_US = 200
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] ascii,
   output logic       key_valid,
   output logic       key_up,
   output logic [7:0] err_count
);

   localparam int TIMEOUT_CYCLES = CLK_FREQ / 1_000_000 * TIMEOUT_US;
   localparam int WD_W           = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   logic [2:0]      clk_sync;
   logic [2:0]      data_sync;
   logic            fall;
   logic [3:0]      bit_cnt;
   logic [9:0]      shift;
   logic [WD_W-1:0] wd_cnt;
   logic            frame_done;
   logic            frame_ok;
   logic            timeout;
   logic            err_inc;
   logic            byte_stb;
   logic [7:0]      byte_data;

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       make_evt;
   logic       brk_evt;
   logic       ext_now;
   logic [8:0] key_now;
   logic [7:0] map_ascii;
   logic [8:0] held_key;
   logic       held_valid;

   // Sync flops reset to the idle-high line level so release never fakes an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync  <= 3'b111;
         data_sync <= 3'b111;
      end else begin
         clk_sync  <= {clk_sync[1:0], ps2_clk};
         data_sync <= {data_sync[1:0], ps2_data};
      end
   end

   assign fall       = (clk_sync[2:1] == 2'b10);
   assign frame_done = fall && (bit_cnt == 4'd10);
   assign frame_ok   = !shift[0] && (^shift[9:1]) && data_sync[2];
   assign timeout    = !fall && (bit_cnt != 4'd0) && (wd_cnt == WD_LAST);
   assign err_inc    = (frame_done && !frame_ok) || timeout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt   <= 4'd0;
         shift     <= 10'd0;
         wd_cnt    <= '0;
         byte_stb  <= 1'b0;
         byte_data <= 8'h00;
      end else begin
         byte_stb <= 1'b0;
         if (fall) begin
            wd_cnt <= '0;
            if (bit_cnt == 4'd10) begin
               bit_cnt <= 4'd0;
               if (frame_ok) begin
                  byte_stb  <= 1'b1;
                  byte_data <= shift[8:1];
               end
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
               shift   <= {data_sync[2], shift[9:1]};
            end
         end else if (timeout) begin
            bit_cnt <= 4'd0;
            wd_cnt  <= '0;
         end else if (bit_cnt != 4'd0) begin
            wd_cnt <= wd_cnt + 1'b1;
         end else begin
            wd_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_count <= 8'h00;
      else if (err_inc && err_count != 8'hFF)
         err_count <= err_count + 8'd1;
   end

   assign ext_now = (state == ST_EXT) || (state == ST_EXT_BRK);
   assign key_now = {ext_now, byte_data};

   ps2_scan_to_ascii u_map (
      .key   (key_now),
      .ascii (map_ascii)
   );

   always_comb begin
      state_nxt = state;
      make_evt  = 1'b0;
      brk_evt   = 1'b0;
      if (byte_stb) begin
         case (state)
            ST_IDLE: begin
               if (byte_data == PS2_EXT)
                  state_nxt = ST_EXT;
               else if (byte_data == PS2_BRK)
                  state_nxt = ST_BRK;
               else if (!is_ignored(byte_data))
                  make_evt = 1'b1;
            end
            ST_EXT: begin
               if (byte_data == PS2_BRK) begin
                  state_nxt = ST_EXT_BRK;
               end else begin
                  make_evt  = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
            default: begin
               brk_evt   = 1'b1;
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // A make of the already-held key is typematic repeat and is swallowed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         ascii      <= 8'h00;
         key_valid  <= 1'b0;
         key_up     <= 1'b0;
         held_key   <= 9'd0;
         held_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         key_valid <= 1'b0;
         key_up    <= 1'b0;
         if (make_evt && map_ascii != 8'h00 &&
             !(held_valid && held_key == key_now)) begin
            held_key   <= key_now;
            held_valid <= 1'b1;
            ascii      <= map_ascii;
            key_valid  <= 1'b1;
         end else if (brk_evt && held_valid && held_key == key_now) begin
            held_key   <= 9'd0;
            held_valid <= 1'b0;
            ascii      <= 8'h00;
            key_up     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed PS/2 frames push expected
// strobes into a queue that a free-running monitor drains.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

   typedef struct packed {
      logic       is_up;
      logic [7:0] ascii;
   } evt_t;

   logic       clk;
   logic       rst_n;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] ascii;
   logic       key_valid;
   logic       key_up;
   logic [7:0] err_count;

   evt_t exp_q[$];
   int   n_checks;
   int   n_pass;
   logic strobe_prev;

   ps2_key_decoder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .ascii     (ascii),
      .key_valid (key_valid),
      .key_up    (key_up),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      n_checks++;
      if (actual === expected)
         n_pass++;
      else
         $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
   endtask

   // Bits go out start, data LSB first, parity, stop; nbits < 11 truncates.
   task automatic send_frame(input logic [7:0] code, input logic good_parity,
                             input int nbits, input int half);
      logic [10:0] bits;
      bits = {1'b1, (good_parity ? ~^code : ^code), code, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = bits[i];
         repeat (half) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (half) @(negedge clk);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      repeat (half) @(negedge clk);
   endtask

   task automatic apply_stimulus(input logic [7:0] code, input logic expect_evt,
                                 input logic is_up, input logic [7:0] exp_ascii);
      evt_t e;
      if (expect_evt) begin
         e.is_up = is_up;
         e.ascii = exp_ascii;
         exp_q.push_back(e);
      end
      send_frame(code, 1'b1, 11, 20);
      repeat (10) @(negedge clk);
   endtask

   always @(negedge clk) begin
      evt_t e;
      if (strobe_prev)
         check_output("strobe_one_cycle", {30'd0, key_valid, key_up}, 32'd0);
      if (key_valid || key_up) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL unexpected_strobe: got valid=%0b up=%0b ascii=%h, required no strobe",
                     key_valid, key_up, ascii);
         end else begin
            e = exp_q.pop_front();
            check_output("strobe_kind", {31'd0, key_up}, {31'd0, e.is_up});
            check_output("strobe_ascii", {24'd0, ascii}, {24'd0, e.ascii});
         end
      end
      strobe_prev = key_valid | key_up;
   end

   initial begin
      n_checks    = 0;
      n_pass      = 0;
      strobe_prev = 1'b0;
      rst_n       = 1'b0;
      ps2_clk     = 1'b1;
      ps2_data    = 1'b1;
      repeat (3) @(negedge clk);
      check_output("reset_ascii", {24'd0, ascii}, 32'h00);
      check_output("reset_key_valid", {31'd0, key_valid}, 32'd0);
      check_output("reset_key_up", {31'd0, key_up}, 32'd0);
      check_output("reset_err", {24'd0, err_count}, 32'h00);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      $display("[TB] make and typematic repeat");
      apply_stimulus(8'h1C, 1'b1, 1'b0, 8'h61);
      check_output("make_a_ascii", {24'd0, ascii}, 32'h61);
      apply_stimulus(8'h1C, 1'b0, 1'b0, 8'h00);
      apply_stimulus(8'h1C, 1'b0, 1'b0, 8'h00);
      check_output("repeat_ascii", {24'd0, ascii}, 32'h61);

      $display("[TB] break handling");
      apply_stimulus(8'hF0, 1'b0, 1'b0, 8'h00);
      apply_stimulus(8'h32, 1'b0, 1'b0, 8'h00);
      check_output("break_other_ascii", {24'd0, ascii}, 32'h61);
      apply_stimulus(8'hF0, 1'b0, 1'b0, 8'h00);
      apply_stimulus(8'h1C, 1'b1, 1'b1, 8'h00);
      check_output("break_held_ascii", {24'd0, ascii}, 32'h00);

      $display("[TB] extended codes and ignored bytes");
      apply_stimulus(8'hE0, 1'b0, 1'b0, 8'h00);
      apply_stimulus(8'h5A, 1'b1, 1'b0, 8'h0D);
      check_output("ext_enter_ascii", {24'd0, ascii}, 32'h0D);
      apply_stimulus(8'hE0, 1'b0, 1'b0, 8'h00);
      apply_stimulus(8'h75, 1'b0, 1'b0, 8'h00);
      apply_stimulus(8'hAA, 1'b0, 1'b0, 8'h00);
      check_output("unmapped_ascii", {24'd0, ascii}, 32'h0D);

      $display("[TB] parity error");
      send_frame(8'h1C, 1'b0, 11, 20);
      repeat (10) @(negedge clk);
      check_output("parity_err_count", {24'd0, err_count}, 32'h01);
      check_output("parity_ascii", {24'd0, ascii}, 32'h0D);
      apply_stimulus(8'h16, 1'b1, 1'b0, 8'h31);
      check_output("digit_1_ascii", {24'd0, ascii}, 32'h31);

      $display("[TB] mid-frame stall");
      send_frame(8'h29, 1'b1, 5, 20);
      repeat (12500) @(negedge clk);
      check_output("timeout_err_count", {24'd0, err_count}, 32'h02);
      apply_stimulus(8'h5A, 1'b1, 1'b0, 8'h0D);
      check_output("resync_enter_ascii", {24'd0, ascii}, 32'h0D);

      $display("[TB] error counter saturation");
      for (int i = 0; i < 253; i++)
         send_frame(8'h00, 1'b0, 11, 4);
      repeat (10) @(negedge clk);
      check_output("err_reach_ff", {24'd0, err_count}, 32'hFF);
      send_frame(8'h00, 1'b0, 11, 4);
      send_frame(8'h00, 1'b0, 11, 4);
      repeat (10) @(negedge clk);
      check_output("err_saturated", {24'd0, err_count}, 32'hFF);

      $display("[TB] reset mid-prefix and mid-frame");
      apply_stimulus(8'hF0, 1'b0, 1'b0, 8'h00);
      send_frame(8'h1C, 1'b1, 4, 20);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_output("midreset_ascii", {24'd0, ascii}, 32'h00);
      check_output("midreset_key_valid", {31'd0, key_valid}, 32'd0);
      check_output("midreset_key_up", {31'd0, key_up}, 32'd0);
      check_output("midreset_err", {24'd0, err_count}, 32'h00);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      apply_stimulus(8'h1C, 1'b1, 1'b0, 8'h61);
      check_output("post_reset_ascii", {24'd0, ascii}, 32'h61);
      check_output("post_reset_err", {24'd0, err_count}, 32'h00);

      repeat (5) @(negedge clk);
      check_output("queue_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
